// File: rtl/multiword_add_pkg.sv
// ============================================================================
// Module   : multiword_add_pkg
// Purpose  : Shared types and constants for the multi-word add/sub sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package multiword_add_pkg;

  // Width of one datapath slice handled per clock.
  localparam int BYTE_W = 8;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : multiword_add_pkg

`default_nettype wire

// File: rtl/multiword_add_ctrl_full_adder_8bit.sv
// ============================================================================
// Module   : full_adder_8bit
// Purpose  : 8-bit ripple-carry adder slice reused once per byte.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder_8bit
  import multiword_add_pkg::*;
(
  input  logic [BYTE_W-1:0] a_in,
  input  logic [BYTE_W-1:0] b_in,
  input  logic              c_in,
  output logic [BYTE_W-1:0] sum_out,
  output logic              c_out
);

  logic [BYTE_W:0] carry_chain;

  assign carry_chain[0] = c_in;

  // One full-adder cell per bit, carries rippling upward.
  generate
    for (genvar i = 0; i < BYTE_W; i++) begin : g_bit
      assign sum_out[i]       = a_in[i] ^ b_in[i] ^ carry_chain[i];
      assign carry_chain[i+1] = (a_in[i] & b_in[i]) | (carry_chain[i] & (a_in[i] ^ b_in[i]));
    end
  endgenerate

  assign c_out = carry_chain[BYTE_W];

endmodule : full_adder_8bit

`default_nettype wire

// File: rtl/multiword_add_ctrl.sv
// ============================================================================
// Module   : multiword_add_ctrl
// Purpose  : Multi-byte add/subtract sequencer, one byte per clock, LSB first,
//            sharing a single 8-bit ripple adder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multiword_add_ctrl
  import multiword_add_pkg::*;
#(
  parameter  int NUM_BYTES = 4,
  localparam int W         = 8 * NUM_BYTES,
  localparam int CNT_W     = $clog2(NUM_BYTES)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_in,
  input  logic         sub_in,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic         carry_in,
  output logic         ready_out,
  output logic [W-1:0] sum_out,
  output logic         carry_out,
  output logic         overflow_out,
  output logic         done_out
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   idx_q,   idx_d;
  logic [W-1:0]       a_q,     a_d;
  logic [W-1:0]       b_q,     b_d;      // already inverted for subtract
  logic               c_q,     c_d;      // inter-byte carry
  logic [W-1:0]       sum_q,   sum_d;
  logic               carry_q, carry_d;
  logic               ovf_q,   ovf_d;
  logic               done_q,  done_d;
  logic               ready_q, ready_d;

  logic [BYTE_W-1:0]  add_a;
  logic [BYTE_W-1:0]  add_b;
  logic [BYTE_W-1:0]  add_sum;
  logic               add_cout;

  // Select the current byte of each operand for the shared adder.
  assign add_a = a_q[idx_q*BYTE_W +: BYTE_W];
  assign add_b = b_q[idx_q*BYTE_W +: BYTE_W];

  full_adder_8bit inst_full_adder_8bit (
    .a_in    (add_a),
    .b_in    (add_b),
    .c_in    (c_q),
    .sum_out (add_sum),
    .c_out   (add_cout)
  );

  // Next-state logic: accept in IDLE, one byte per RUN cycle, pulse in DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    ready_d = ready_q;

    case (state_q)
      IDLE: begin
        if (start_in) begin
          // Subtract is a + ~b + 1; the caller's carry_in is ignored then.
          a_d     = a_in;
          b_d     = sub_in ? ~b_in : b_in;
          c_d     = sub_in ? 1'b1 : carry_in;
          sum_d   = '0;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          idx_d   = '0;
          ready_d = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*BYTE_W +: BYTE_W] = add_sum;
        c_d = add_cout;
        if (idx_q == LAST_IDX) begin
          // Signed overflow: like-signed inputs produced a differently-signed result.
          carry_d = add_cout;
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_sum[BYTE_W-1] != a_q[W-1]);
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign ready_out    = ready_q;
  assign sum_out      = sum_q;
  assign carry_out    = carry_q;
  assign overflow_out = ovf_q;
  assign done_out     = done_q;

endmodule : multiword_add_ctrl

`default_nettype wire

// File: tb/tb_multiword_add_ctrl.sv
// ============================================================================
// Module   : tb_multiword_add_ctrl
// Purpose  : Directed self-checking bench for multiword_add_ctrl (4 bytes).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multiword_add_ctrl;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk;
  logic         rst_n;
  logic         start_in;
  logic         sub_in;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         carry_in;
  logic         ready_out;
  logic [W-1:0] sum_out;
  logic         carry_out;
  logic         overflow_out;
  logic         done_out;

  int total = 0;
  int bad   = 0;

  multiword_add_ctrl #(.NUM_BYTES(NB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_in     (start_in),
    .sub_in       (sub_in),
    .a_in         (a_in),
    .b_in         (b_in),
    .carry_in     (carry_in),
    .ready_out    (ready_out),
    .sum_out      (sum_out),
    .carry_out    (carry_out),
    .overflow_out (overflow_out),
    .done_out     (done_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op from IDLE, wait (bounded) for done, check latency and results.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic cin, input logic [W-1:0] exp_sum,
                        input logic exp_c, input logic exp_o);
    int lat;
    a_in = a; b_in = b; sub_in = sub; carry_in = cin; start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    lat = 1;
    while (!done_out && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_done"},    W'(done_out),     W'(1));
    chk({tag, "_latency"}, W'(lat),          W'(5));
    chk({tag, "_sum"},     sum_out,          exp_sum);
    chk({tag, "_carry"},   W'(carry_out),    W'(exp_c));
    chk({tag, "_ovf"},     W'(overflow_out), W'(exp_o));
    @(negedge clk);
    chk({tag, "_done_clr"}, W'(done_out),  W'(0));
    chk({tag, "_ready"},    W'(ready_out), W'(1));
    chk({tag, "_hold"},     sum_out,       exp_sum);
  endtask

  logic [W:0]   exp_full [3];
  logic         exp_ovf  [3];
  logic [W-1:0] bb;

  initial begin
    rst_n = 1'b0; start_in = 1'b0; sub_in = 1'b0; a_in = '0; b_in = '0; carry_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", W'(ready_out),    W'(1));
    chk("rst_sum",   sum_out,          '0);
    chk("rst_carry", W'(carry_out),    W'(0));
    chk("rst_ovf",   W'(overflow_out), W'(0));
    chk("rst_done",  W'(done_out),     W'(0));
    rst_n = 1'b1;
    @(negedge clk);

    run_op("t1_ff_plus_1",   32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0);
    run_op("t2_wrap",        32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
    run_op("t2_wrap_cin",    32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1, 32'h00000001, 1'b1, 1'b0);
    run_op("t3_pos_ovf",     32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
    run_op("t3_neg_ovf",     32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1);
    run_op("t4_sub_borrow",  32'h00000005, 32'h00000007, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0);
    run_op("t4_sub_ok_cin",  32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0);

    // Continuous start with operands changing every cycle: only cycles 0, 6, 12 accept.
    for (int i = 0; i < 18; i++) begin
      a_in     = 32'h01020304 * (i + 1) + 32'h9000_0000;
      b_in     = 32'h00F0F00F ^ (32'h11111111 * i);
      sub_in   = (((i / 6) % 2) == 1) ^ ((i % 2) == 1);
      carry_in = (i % 3) == 0;
      start_in = 1'b1;
      if ((i % 6) == 0) begin
        bb = sub_in ? ~b_in : b_in;
        exp_full[i/6] = {1'b0, a_in} + {1'b0, bb} + (sub_in ? 33'd1 : {32'd0, carry_in});
        exp_ovf[i/6]  = (a_in[W-1] == bb[W-1]) && (exp_full[i/6][W-1] != a_in[W-1]);
      end
      @(negedge clk);
      chk($sformatf("t5_ready_%0d", i), W'(ready_out), W'((i % 6) == 5));
      chk($sformatf("t5_done_%0d", i),  W'(done_out),  W'((i % 6) == 4));
      if ((i % 6) == 4) begin
        chk($sformatf("t5_sum_%0d", i),   sum_out,          exp_full[i/6][W-1:0]);
        chk($sformatf("t5_carry_%0d", i), W'(carry_out),    W'(exp_full[i/6][W]));
        chk($sformatf("t5_ovf_%0d", i),   W'(overflow_out), W'(exp_ovf[i/6]));
      end
    end
    start_in = 1'b0;
    @(negedge clk);

    // Reset while idx=2: partial sum bytes are discarded and no done pulse follows.
    a_in = 32'h11223344; b_in = 32'h01010101; sub_in = 1'b0; carry_in = 1'b0; start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t6_ready", W'(ready_out),    W'(1));
    chk("t6_sum",   sum_out,          '0);
    chk("t6_carry", W'(carry_out),    W'(0));
    chk("t6_ovf",   W'(overflow_out), W'(0));
    chk("t6_done",  W'(done_out),     W'(0));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("t6_nodone_%0d", k), W'(done_out), W'(0));
    end
    run_op("t6_after", 32'h11223344, 32'h01010101, 1'b0, 1'b0, 32'h12233445, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_multiword_add_ctrl

`default_nettype wire
